// File: rtl/table_fsm_core.sv
// Rule-table driven state machine: next state comes from a run-time loadable
// first-match table of (state, masked input) -> next-state rules.
module table_fsm_core #(
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned IN_W        = 4,
    parameter int unsigned N_RULES     = 64,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned RESET_STATE = 0,
    localparam int unsigned AW         = (N_RULES > 1) ? $clog2(N_RULES) : 1,
    localparam int unsigned ENTRY_W    = 1 + 2*STATE_W + 2*IN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [IN_W-1:0]    impact,
    input  logic               ld,
    input  logic [STATE_W-1:0] ld_state,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_wdata,
    output logic [ENTRY_W-1:0] cfg_rdata,
    output logic [STATE_W-1:0] result,
    output logic               hit,
    output logic [CNT_W-1:0]   step_cnt
);

    // Field positions inside an entry (valid bit held separately)
    localparam int unsigned FLD_W     = ENTRY_W - 1;
    localparam int unsigned NXT_LSB   = 0;
    localparam int unsigned CARE_LSB  = STATE_W;
    localparam int unsigned MATCH_LSB = STATE_W + IN_W;
    localparam int unsigned CUR_LSB   = STATE_W + 2*IN_W;

    logic [FLD_W-1:0]   rule_mem [N_RULES];
    logic [N_RULES-1:0] valid_q, valid_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ENTRY_W-1:0] rdata_q, rdata_d;

    logic               addr_ok_c;
    logic               any_match_c;
    logic [STATE_W-1:0] match_next_c;

    assign addr_ok_c = (32'(cfg_addr) < N_RULES);

    // First-match search over the pre-write table
    always_comb begin
        any_match_c  = 1'b0;
        match_next_c = state_q;
        for (int unsigned i = 0; i < N_RULES; i++) begin
            if (!any_match_c && valid_q[i] &&
                (rule_mem[i][CUR_LSB +: STATE_W] == state_q) &&
                (((impact ^ rule_mem[i][MATCH_LSB +: IN_W]) &
                  rule_mem[i][CARE_LSB +: IN_W]) == '0)) begin
                any_match_c  = 1'b1;
                match_next_c = rule_mem[i][NXT_LSB +: STATE_W];
            end
        end
    end

    // State, hit, counter, valid bits and readback next values
    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        rdata_d = '0;

        if (ld) begin
            state_d = ld_state;
            cnt_d   = '0;
        end else if (en && any_match_c) begin
            state_d = match_next_c;
            hit_d   = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (addr_ok_c) begin
            rdata_d = {valid_q[cfg_addr], rule_mem[cfg_addr]};
            if (cfg_we) begin
                valid_d[cfg_addr] = cfg_wdata[ENTRY_W-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_W'(RESET_STATE);
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    // Rule payload storage is not reset; the valid bit gates it
    always_ff @(posedge clk) begin
        if (cfg_we && addr_ok_c) begin
            rule_mem[cfg_addr] <= cfg_wdata[FLD_W-1:0];
        end
    end

    assign result    = state_q;
    assign hit       = hit_q;
    assign step_cnt  = cnt_q;
    assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_table_fsm_core.sv
// Scoreboard bench: two instances (default and small/saturating) share stimulus,
// a table-level reference model predicts every cycle, a monitor compares.
module tb_table_fsm_core;

    typedef struct {
        logic [3:0]  res;
        logic        hit;
        logic [15:0] cnt;
        logic [16:0] rd;
        bit          rchk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, ld = 1'b0, cfg_we = 1'b0;
    logic [3:0]  impact = '0, ld_state = '0;
    logic [5:0]  cfg_addr = '0;
    logic [16:0] cfg_wdata = '0;

    logic [16:0] rd0, rd1;
    logic [3:0]  res0, res1;
    logic        hit0, hit1;
    logic [15:0] cnt0;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: per instance, rule list plus state/counter
    bit [15:0]   m_f [2][64];
    bit          m_v [2][64];
    bit          m_k [2][64];
    logic [3:0]  m_st [2];
    bit          m_hit [2];
    int unsigned m_cnt [2];
    int unsigned n_rules [2] = '{64, 5};
    int unsigned cnt_max [2] = '{65535, 7};

    always #5 clk = ~clk;

    table_fsm_core u0 (
        .clk(clk), .rst(rst), .en(en), .impact(impact), .ld(ld), .ld_state(ld_state),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(rd0),
        .result(res0), .hit(hit0), .step_cnt(cnt0)
    );

    table_fsm_core #(.N_RULES(5), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .en(en), .impact(impact), .ld(ld), .ld_state(ld_state),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr[2:0]), .cfg_wdata(cfg_wdata), .cfg_rdata(rd1),
        .result(res1), .hit(hit1), .step_cnt(cnt1)
    );

    function automatic logic [16:0] rule(input bit v, input logic [3:0] c, input logic [3:0] m,
                                         input logic [3:0] k, input logic [3:0] n);
        return {v, c, m, k, n};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cycle(input int d, input bit r, output exp_t e);
        int unsigned a;
        int w;
        a = (d == 0) ? int'(cfg_addr) : int'(cfg_addr) % 8;
        w = -1;
        if (r) begin
            m_st[d]  = 4'd0;
            m_hit[d] = 1'b0;
            m_cnt[d] = 0;
            for (int i = 0; i < 64; i++) m_v[d][i] = 1'b0;
            e.rd   = '0;
            e.rchk = 1'b1;
        end else begin
            if (a < n_rules[d]) begin
                e.rd   = {m_v[d][a], m_f[d][a]};
                e.rchk = m_k[d][a];
            end else begin
                e.rd   = '0;
                e.rchk = 1'b1;
            end
            for (int i = 0; i < int'(n_rules[d]); i++) begin
                if (w < 0 && m_v[d][i] && m_f[d][i][15:12] == m_st[d] &&
                    ((impact ^ m_f[d][i][11:8]) & m_f[d][i][7:4]) == 4'd0)
                    w = i;
            end
            if (ld) begin
                m_st[d]  = ld_state;
                m_hit[d] = 1'b0;
                m_cnt[d] = 0;
            end else if (en && w >= 0) begin
                m_st[d]  = m_f[d][w][3:0];
                m_hit[d] = 1'b1;
                if (m_cnt[d] < cnt_max[d]) m_cnt[d] = m_cnt[d] + 1;
            end else begin
                m_hit[d] = 1'b0;
            end
            if (cfg_we && a < n_rules[d]) begin
                m_f[d][a] = cfg_wdata[15:0];
                m_v[d][a] = cfg_wdata[16];
                m_k[d][a] = 1'b1;
            end
        end
        e.res = m_st[d];
        e.hit = m_hit[d];
        e.cnt = 16'(m_cnt[d]);
    endtask

    task automatic cyc(input bit e_, input logic [3:0] imp, input bit l, input logic [3:0] ls,
                       input bit we, input logic [5:0] a, input logic [16:0] wd);
        exp_t x0, x1;
        @(negedge clk);
        rst = 1'b0; en = e_; impact = imp; ld = l; ld_state = ls;
        cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        model_cycle(0, 1'b0, x0);
        model_cycle(1, 1'b0, x1);
        q0.push_back(x0);
        q1.push_back(x1);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock
    task automatic do_reset();
        exp_t x0, x1;
        @(negedge clk);
        en = 1'b0; ld = 1'b0; cfg_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_result0", 32'(res0), 0);
        chk("rst_hit0", 32'(hit0), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_rdata0", 32'(rd0), 0);
        chk("rst_result1", 32'(res1), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        model_cycle(0, 1'b1, x0);
        model_cycle(1, 1'b1, x1);
        q0.push_back(x0);
        q1.push_back(x1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per modeled clock edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                x = q0.pop_front();
                chk("sb0_result", 32'(res0), 32'(x.res));
                chk("sb0_hit", 32'(hit0), 32'(x.hit));
                chk("sb0_cnt", 32'(cnt0), 32'(x.cnt));
                if (x.rchk) chk("sb0_rdata", 32'(rd0), 32'(x.rd));
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                chk("sb1_result", 32'(res1), 32'(x.res));
                chk("sb1_hit", 32'(hit1), 32'(x.hit));
                chk("sb1_cnt", 32'(cnt1), 32'(x.cnt));
                if (x.rchk) chk("sb1_rdata", 32'(rd1), 32'(x.rd));
            end
        end
    end

    initial begin
        do_reset();

        // basic hit with don't-care bit 0
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 6'd0, rule(1'b1, 4'd0, 4'b0000, 4'b1110, 4'd2));
        cyc(1'b1, 4'b0001, 1'b0, 4'd0, 1'b0, 6'd0, '0);
        settle();
        chk("t1_result", 32'(res0), 2);
        chk("t1_hit", 32'(hit0), 1);
        chk("t1_cnt", 32'(cnt0), 1);

        // first-match priority
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 6'd3, rule(1'b1, 4'd2, 4'b0000, 4'b0000, 4'd5));
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 6'd1, rule(1'b1, 4'd2, 4'b0110, 4'b1111, 4'd7));
        cyc(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, 6'd0, '0);
        settle();
        chk("t2_rule1", 32'(res0), 7);
        cyc(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 6'd0, '0);
        cyc(1'b1, 4'b1001, 1'b0, 4'd0, 1'b0, 6'd0, '0);
        settle();
        chk("t2_rule3", 32'(res0), 5);
        chk("t2_cnt_after_ld", 32'(cnt0), 1);

        // miss holds state and count
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'($urandom), 1'b0, 4'd0, 1'b0, 6'd0, '0);
        settle();
        chk("t3_result", 32'(res0), 5);
        chk("t3_hit", 32'(hit0), 0);
        chk("t3_cnt", 32'(cnt0), 1);

        // ld wins over a matching rule
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 6'd4, rule(1'b1, 4'd5, 4'b0000, 4'b0000, 4'd6));
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 6'd2, rule(1'b1, 4'd9, 4'b0000, 4'b0000, 4'd3));
        cyc(1'b1, 4'd0, 1'b1, 4'd9, 1'b0, 6'd0, '0);
        settle();
        chk("t4_ld_result", 32'(res0), 9);
        chk("t4_ld_hit", 32'(hit0), 0);
        chk("t4_ld_cnt", 32'(cnt0), 0);
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 6'd0, '0);
        settle();
        chk("t4_after_result", 32'(res0), 3);
        chk("t4_after_hit", 32'(hit0), 1);

        // same-cycle write and step uses old table; readback is read-before-write
        do_reset();
        cyc(1'b1, 4'($urandom), 1'b0, 4'd0, 1'b1, 6'd0, rule(1'b1, 4'd0, 4'b0000, 4'b0000, 4'd4));
        settle();
        chk("t5_old_result", 32'(res0), 0);
        chk("t5_old_rdata", 32'(rd0), 32'h000E2);
        cyc(1'b1, 4'($urandom), 1'b0, 4'd0, 1'b0, 6'd0, '0);
        settle();
        chk("t5_new_result", 32'(res0), 4);
        chk("t5_new_rdata", 32'(rd0), 32'h10004);

        // self-loop saturation on the 3-bit counter, then reset clears rules
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 6'd1, rule(1'b1, 4'd4, 4'b0000, 4'b0000, 4'd4));
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'($urandom), 1'b0, 4'd0, 1'b0, 6'd1, '0);
        settle();
        chk("t6_result", 32'(res1), 4);
        chk("t6_cnt_sat", 32'(cnt1), 7);
        chk("t6_cnt_wide", 32'(cnt0), 11);
        do_reset();
        cyc(1'b1, 4'($urandom), 1'b0, 4'd0, 1'b0, 6'd0, '0);
        cyc(1'b1, 4'($urandom), 1'b0, 4'd0, 1'b0, 6'd0, '0);
        settle();
        chk("t6_no_hit", 32'(hit0), 0);
        chk("t6_rule_invalid", 32'(rd0[16]), 0);

        // out-of-range address on the 5-entry instance
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 6'd6, rule(1'b1, 4'd0, 4'd0, 4'd0, 4'd1));
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 6'd6, '0);
        settle();
        chk("oob_rdata1", 32'(rd1), 0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 19) == 0,
                    4'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom),
                    rule($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 4'($urandom),
                         4'($urandom) & 4'($urandom), 4'($urandom_range(0, 7))));
            end
        end
        settle();
        @(posedge clk);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
